// File: rtl/pixel_palette_mixer.sv
// pixel_palette_mixer
//   DMG palette datapath sequencer for the pixel pipe. Takes one BG pixel per
//   handshake together with an optional overlapping object pixel, resolves
//   BG/OBJ priority, maps the winner through BGP/OBP0/OBP1 and queues the
//   resulting 2-bit shades for the LCD driver.
//
//   Pipeline: accept edge (p1 capture) -> shade lookup (p2) -> FIFO write.
//   A pixel accepted at edge N is written to the FIFO at edge N+2; the FIFO
//   is first-word fall-through.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   line_start                 1-cycle flush of pipe, FIFO and pixel count
//   bg_valid/bg_pix            BG pixel offer and colour index
//   obj_valid/obj_pix/obj_pal/obj_behind
//                              overlapping object pixel, sampled with BG
//   bg_en, obj_en              LCDC.0 / LCDC.1
//   bgp_d, obp0_d, obp1_d      palettes from the palette register block
//   in_ready                   pixel accepted when bg_valid && in_ready
//   shade/shade_valid/shade_ready
//                              output shade stream (0 = lightest)
//   line_done                  pulse after the last shade of a full line pops
//   pix_count                  pixels accepted this line (saturating)
module pixel_palette_mixer #(
    parameter int DEPTH           = 4,
    parameter int PIXELS_PER_LINE = 160
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       line_start,
    input  logic       bg_valid,
    input  logic [1:0] bg_pix,
    input  logic       obj_valid,
    input  logic [1:0] obj_pix,
    input  logic       obj_pal,
    input  logic       obj_behind,
    input  logic       bg_en,
    input  logic       obj_en,
    input  logic [7:0] bgp_d,
    input  logic [7:0] obp0_d,
    input  logic [7:0] obp1_d,
    output logic       in_ready,
    output logic [1:0] shade,
    output logic       shade_valid,
    input  logic       shade_ready,
    output logic       line_done,
    output logic [7:0] pix_count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [7:0]  PPL     = 8'(PIXELS_PER_LINE);
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

    function automatic logic [1:0] pal_lookup(input logic [7:0] pal,
                                              input logic [1:0] idx);
        return pal[{idx, 1'b1} -: 2];
    endfunction

    function automatic logic obj_wins(input logic       ov,
                                      input logic       oen,
                                      input logic [1:0] op,
                                      input logic       behind,
                                      input logic [1:0] bgi);
        return ov && oen && (op != 2'd0) && !(behind && (bgi != 2'd0));
    endfunction

    // Control state
    logic          rdy_en_q;
    logic          vld_p1_q, vld_p1_d;
    logic          vld_p2_q, vld_p2_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    pix_count_q, pix_count_d;
    logic          line_done_q, line_done_d;

    // Datapath state (not reset; qualified by the valid bits)
    logic [1:0]    idx_p1_q;
    logic [7:0]    pal_p1_q;
    logic          zero_p1_q;
    logic [1:0]    shade_p2_q;
    logic [1:0]    mem_q [DEPTH];

    logic          full_line;
    logic [CW:0]   inflight;
    logic          accept;
    logic          push;
    logic          pop;
    logic [1:0]    bg_idx;
    logic          win_obj;

    assign full_line = (pix_count_q == PPL);
    // Pipe stages count as occupied so every accepted pixel has a FIFO slot.
    assign inflight  = {1'b0, cnt_q} + {{CW{1'b0}}, vld_p1_q} + {{CW{1'b0}}, vld_p2_q};
    assign in_ready  = rdy_en_q && !full_line && (inflight < DEPTH_C);
    assign accept    = bg_valid && in_ready && !line_start;
    assign push      = vld_p2_q && !line_start;
    assign pop       = shade_valid && shade_ready && !line_start;

    assign bg_idx    = bg_en ? bg_pix : 2'd0;
    assign win_obj   = obj_wins(obj_valid, obj_en, obj_pix, obj_behind, bg_idx);

    assign shade_valid = (cnt_q != '0);
    assign shade       = shade_valid ? mem_q[rd_ptr_q] : 2'd0;
    assign line_done   = line_done_q;
    assign pix_count   = pix_count_q;

    always_comb begin
        vld_p1_d    = accept;
        vld_p2_d    = vld_p1_q && !line_start;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        cnt_d       = cnt_q;
        pix_count_d = pix_count_q;
        // Last shade of a full line leaves the FIFO with nothing behind it.
        line_done_d = pop && (cnt_q == CW'(1)) && !vld_p1_q && !vld_p2_q && full_line;

        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase

        if (accept && !full_line) pix_count_d = pix_count_q + 8'd1;

        if (line_start) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            cnt_d       = '0;
            pix_count_d = '0;
            line_done_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_en_q    <= 1'b0;
            vld_p1_q    <= 1'b0;
            vld_p2_q    <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            pix_count_q <= '0;
            line_done_q <= 1'b0;
        end else begin
            rdy_en_q    <= 1'b1;
            vld_p1_q    <= vld_p1_d;
            vld_p2_q    <= vld_p2_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            pix_count_q <= pix_count_d;
            line_done_q <= line_done_d;
        end
    end

    // Stage p1: capture winner index and its palette at the accept edge, so
    // later palette writes never affect this pixel.
    always_ff @(posedge clk) begin
        if (accept) begin
            idx_p1_q  <= win_obj ? obj_pix : bg_idx;
            pal_p1_q  <= win_obj ? (obj_pal ? obp1_d : obp0_d) : bgp_d;
            zero_p1_q <= !win_obj && !bg_en;
        end
    end

    // Stage p2: palette lookup; a disabled BG forces the lightest shade.
    always_ff @(posedge clk) begin
        if (vld_p1_q) begin
            shade_p2_q <= zero_p1_q ? 2'd0 : pal_lookup(pal_p1_q, idx_p1_q);
        end
    end

    // Output FIFO storage
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= shade_p2_q;
        end
    end

endmodule

// File: tb/tb_pixel_palette_mixer.sv
module tb_pixel_palette_mixer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       line_start;
    logic       bg_valid;
    logic [1:0] bg_pix;
    logic       obj_valid;
    logic [1:0] obj_pix;
    logic       obj_pal;
    logic       obj_behind;
    logic       bg_en;
    logic       obj_en;
    logic [7:0] bgp_d;
    logic [7:0] obp0_d;
    logic [7:0] obp1_d;
    logic       in_ready;
    logic [1:0] shade;
    logic       shade_valid;
    logic       shade_ready;
    logic       line_done;
    logic [7:0] pix_count;

    int checks = 0;
    int errors = 0;
    int ld_count = 0;
    int exp_pix = 0;
    logic [1:0] q[$];

    pixel_palette_mixer #(.DEPTH(4), .PIXELS_PER_LINE(160)) dut (
        .clk(clk), .rst_n(rst_n), .line_start(line_start),
        .bg_valid(bg_valid), .bg_pix(bg_pix),
        .obj_valid(obj_valid), .obj_pix(obj_pix), .obj_pal(obj_pal),
        .obj_behind(obj_behind), .bg_en(bg_en), .obj_en(obj_en),
        .bgp_d(bgp_d), .obp0_d(obp0_d), .obp1_d(obp1_d),
        .in_ready(in_ready), .shade(shade), .shade_valid(shade_valid),
        .shade_ready(shade_ready), .line_done(line_done), .pix_count(pix_count)
    );

    always #5 clk = ~clk;

    // Record every real pop and every line_done pulse.
    always @(negedge clk) begin
        if (rst_n && !line_start && shade_valid && shade_ready) q.push_back(shade);
        if (rst_n && line_done) ld_count++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [1:0] b, input logic ov, input logic [1:0] op,
                        input logic pl, input logic bh);
        int n;
        logic acc;
        bg_pix = b; obj_valid = ov; obj_pix = op; obj_pal = pl; obj_behind = bh;
        bg_valid = 1'b1;
        n = 0;
        acc = 1'b0;
        while (!acc && n < 50) begin
            acc = in_ready;
            tick();
            n++;
        end
        bg_valid = 1'b0;
        obj_valid = 1'b0;
        chk("push_accept", {31'd0, acc}, 32'd1);
        if (acc) exp_pix++;
    endtask

    task automatic wait_q(input int n);
        int c;
        c = 0;
        while (q.size() < n && c < 400) begin
            tick();
            c++;
        end
        chk("queue_len", q.size(), n);
    endtask

    task automatic pop_chk(input string tag, input logic [1:0] exp);
        logic [1:0] v;
        if (q.size() > 0) v = q.pop_front();
        else v = 2'bxx;
        chk(tag, {30'd0, v}, {30'd0, exp});
    endtask

    initial begin
        int n;
        logic acc;
        rst_n = 1'b0; line_start = 1'b0; bg_valid = 1'b0; bg_pix = 2'd0;
        obj_valid = 1'b0; obj_pix = 2'd0; obj_pal = 1'b0; obj_behind = 1'b0;
        bg_en = 1'b1; obj_en = 1'b1;
        bgp_d = 8'hE4; obp0_d = 8'hD2; obp1_d = 8'h1B;
        shade_ready = 1'b1;

        // Reset state
        tick(); tick(); tick();
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_shade_valid", {31'd0, shade_valid}, 32'd0);
        chk("rst_shade", {30'd0, shade}, 32'd0);
        chk("rst_line_done", {31'd0, line_done}, 32'd0);
        chk("rst_pix_count", {24'd0, pix_count}, 32'd0);
        rst_n = 1'b1;
        chk("rst_release_ready_low", {31'd0, in_ready}, 32'd0);
        tick();
        chk("rst_release_ready_high", {31'd0, in_ready}, 32'd1);

        // Test 1: BGP=E4, indices 0..3 back-to-back, latency of two edges
        q.delete();
        push(2'd0, 1'b0, 2'd0, 1'b0, 1'b0);
        chk("t1_valid_n", {31'd0, shade_valid}, 32'd0);
        push(2'd1, 1'b0, 2'd0, 1'b0, 1'b0);
        chk("t1_valid_n1", {31'd0, shade_valid}, 32'd0);
        push(2'd2, 1'b0, 2'd0, 1'b0, 1'b0);
        chk("t1_valid_n2", {31'd0, shade_valid}, 32'd1);
        chk("t1_shade_n2", {30'd0, shade}, 32'd0);
        push(2'd3, 1'b0, 2'd0, 1'b0, 1'b0);
        wait_q(4);
        pop_chk("t1_s0", 2'd0);
        pop_chk("t1_s1", 2'd1);
        pop_chk("t1_s2", 2'd2);
        pop_chk("t1_s3", 2'd3);

        // Test 2: BG/OBJ priority and object palettes
        q.delete();
        push(2'd1, 1'b1, 2'd2, 1'b0, 1'b0);  // OBP0 idx2 -> 1
        push(2'd1, 1'b1, 2'd2, 1'b1, 1'b0);  // OBP1 idx2 -> 1
        push(2'd1, 1'b1, 2'd1, 1'b0, 1'b0);  // OBP0 idx1 -> 0
        push(2'd1, 1'b1, 2'd1, 1'b1, 1'b0);  // OBP1 idx1 -> 2
        push(2'd1, 1'b1, 2'd2, 1'b0, 1'b1);  // behind BG 1 -> BGP idx1 -> 1
        push(2'd0, 1'b1, 2'd3, 1'b0, 1'b1);  // behind BG 0 -> OBP0 idx3 -> 3
        push(2'd2, 1'b1, 2'd3, 1'b1, 1'b0);  // OBP1 idx3 -> 0
        wait_q(7);
        pop_chk("t2_obp0_i2", 2'd1);
        pop_chk("t2_obp1_i2", 2'd1);
        pop_chk("t2_obp0_i1", 2'd0);
        pop_chk("t2_obp1_i1", 2'd2);
        pop_chk("t2_behind_bg", 2'd1);
        pop_chk("t2_behind_bg0", 2'd3);
        pop_chk("t2_obj_over", 2'd0);

        // Test 3: transparent object, obj disabled, palette sampling, bg disabled
        q.delete();
        push(2'd2, 1'b1, 2'd0, 1'b0, 1'b0);  // transparent obj -> BGP idx2 -> 2
        obj_en = 1'b0;
        push(2'd3, 1'b1, 2'd1, 1'b0, 1'b0);  // obj disabled -> 3
        obj_en = 1'b1;
        push(2'd1, 1'b0, 2'd0, 1'b0, 1'b0);  // BGP=E4 idx1 -> 1
        bgp_d = 8'h1B;
        push(2'd1, 1'b0, 2'd0, 1'b0, 1'b0);  // BGP=1B idx1 -> 2
        bgp_d = 8'hFF;
        bg_en = 1'b0;
        push(2'd3, 1'b0, 2'd0, 1'b0, 1'b0);  // bg disabled -> 0
        push(2'd3, 1'b1, 2'd2, 1'b0, 1'b1);  // bg masked to 0, obj wins -> 1
        bg_en = 1'b1;
        bgp_d = 8'hE4;
        wait_q(6);
        pop_chk("t3_obj_transp", 2'd2);
        pop_chk("t3_obj_dis", 2'd3);
        pop_chk("t3_pal_old", 2'd1);
        pop_chk("t3_pal_new", 2'd2);
        pop_chk("t3_bg_dis", 2'd0);
        pop_chk("t3_bg_dis_obj", 2'd1);
        chk("t3_pix_count", {24'd0, pix_count}, exp_pix);

        // Test 4: back-pressure, in_ready falls with four in flight
        q.delete();
        shade_ready = 1'b0;
        n = 0;
        for (int k = 0; k < 8; k++) begin
            bg_pix = 2'(3 - n);
            bg_valid = 1'b1;
            acc = in_ready;
            tick();
            if (acc) n++;
        end
        bg_valid = 1'b0;
        exp_pix += n;
        chk("t4_accepts", n, 4);
        chk("t4_in_ready_low", {31'd0, in_ready}, 32'd0);
        chk("t4_head_valid", {31'd0, shade_valid}, 32'd1);
        chk("t4_head_shade", {30'd0, shade}, 32'd3);
        shade_ready = 1'b1;
        chk("t4_ready_same_cycle", {31'd0, in_ready}, 32'd0);
        tick();
        chk("t4_ready_after_pop", {31'd0, in_ready}, 32'd1);
        wait_q(4);
        pop_chk("t4_s0", 2'd3);
        pop_chk("t4_s1", 2'd2);
        pop_chk("t4_s2", 2'd1);
        pop_chk("t4_s3", 2'd0);
        chk("t4_pix_count", {24'd0, pix_count}, exp_pix);

        // Test 5: full line of 160 pixels
        line_start = 1'b1;
        tick();
        line_start = 1'b0;
        exp_pix = 0;
        chk("t5_start_count", {24'd0, pix_count}, 32'd0);
        q.delete();
        ld_count = 0;
        for (int i = 0; i < 160; i++) push(2'(i % 4), 1'b0, 2'd0, 1'b0, 1'b0);
        chk("t5_pix_count", {24'd0, pix_count}, 32'd160);
        chk("t5_in_ready_full", {31'd0, in_ready}, 32'd0);
        wait_q(160);
        chk("t5_no_early_done", ld_count, 0);
        tick(); tick(); tick();
        chk("t5_line_done_once", ld_count, 1);
        for (int i = 0; i < 160; i++) pop_chk("t5_shade", 2'(i % 4));
        bg_valid = 1'b1;
        tick(); tick(); tick();
        bg_valid = 1'b0;
        tick(); tick(); tick();
        chk("t5_sat_count", {24'd0, pix_count}, 32'd160);
        chk("t5_no_extra", q.size(), 0);
        chk("t5_line_done_still_once", ld_count, 1);
        line_start = 1'b1;
        tick();
        line_start = 1'b0;
        exp_pix = 0;
        chk("t5_restart_count", {24'd0, pix_count}, 32'd0);
        chk("t5_restart_ready", {31'd0, in_ready}, 32'd1);

        // Test 6: line_start flush against a queued FIFO and a same-cycle accept
        q.delete();
        shade_ready = 1'b0;
        push(2'd1, 1'b0, 2'd0, 1'b0, 1'b0);
        push(2'd2, 1'b0, 2'd0, 1'b0, 1'b0);
        push(2'd3, 1'b0, 2'd0, 1'b0, 1'b0);
        tick(); tick(); tick();
        chk("t6_queued", {31'd0, shade_valid}, 32'd1);
        bg_pix = 2'd2;
        bg_valid = 1'b1;
        line_start = 1'b1;
        tick();
        line_start = 1'b0;
        bg_valid = 1'b0;
        exp_pix = 0;
        chk("t6_flush_valid", {31'd0, shade_valid}, 32'd0);
        chk("t6_flush_count", {24'd0, pix_count}, 32'd0);
        chk("t6_flush_ready", {31'd0, in_ready}, 32'd1);
        tick(); tick(); tick(); tick();
        chk("t6_discarded", {31'd0, shade_valid}, 32'd0);
        shade_ready = 1'b1;
        tick(); tick(); tick();
        chk("t6_no_pops", q.size(), 0);
        chk("t6_no_line_done", ld_count, 1);

        // Asynchronous reset mid-stream
        shade_ready = 1'b0;
        bg_pix = 2'd1;
        bg_valid = 1'b1;
        tick(); tick(); tick(); tick();
        rst_n = 1'b0;
        #1;
        chk("ar_in_ready", {31'd0, in_ready}, 32'd0);
        chk("ar_shade_valid", {31'd0, shade_valid}, 32'd0);
        chk("ar_shade", {30'd0, shade}, 32'd0);
        chk("ar_line_done", {31'd0, line_done}, 32'd0);
        chk("ar_pix_count", {24'd0, pix_count}, 32'd0);
        bg_valid = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        tick();
        chk("ar_release_ready", {31'd0, in_ready}, 32'd1);
        shade_ready = 1'b1;
        tick(); tick(); tick(); tick();
        chk("ar_lost_shades", {31'd0, shade_valid}, 32'd0);
        chk("ar_no_pops", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
